// File: rtl/ysyx_22050243_lsu.sv
// ============================================================================
// Module   : ysyx_22050243_lsu
// Purpose  : Load/store unit. Issues one aligned 64-bit bus request per memory
//            op and returns the extended load data. Stalls the pipeline meanwhile.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22050243_lsu #(
    parameter int XLEN = 64,
    parameter int AW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            mem_r,
    input  logic            mem_w,
    input  logic [2:0]      funct3,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    output logic            lsu_busy,
    output logic            lsu_done,
    output logic            lsu_err,
    output logic [XLEN-1:0] rdata,
    output logic            req_valid,
    input  logic            req_ready,
    output logic            req_we,
    output logic [AW-1:0]   req_addr,
    output logic [XLEN-1:0] req_wdata,
    output logic [7:0]      req_wmask,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RESP = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic               r_we;
    logic [1:0]         r_size;
    logic               r_sign;
    logic [2:0]         r_off;
    logic [AW-1:0]      r_addr;
    logic [XLEN-1:0]    r_wdata;
    logic [7:0]         r_wmask;
    logic [XLEN-1:0]    r_rdata;

    logic               w_start;
    logic               w_misaligned;
    logic               w_illegal;
    logic               w_err_cond;
    logic [7:0]         w_size_mask;
    logic [XLEN-1:0]    w_shifted;
    logic [XLEN-1:0]    w_load;

    // Op decode: alignment, legality and the unshifted byte-enable pattern
    always_comb begin
        w_start      = (r_state == S_IDLE) & ex_valid & (mem_r ^ mem_w);
        w_misaligned = 1'b0;
        w_size_mask  = 8'h00;
        case (funct3[1:0])
            2'd0: begin
                w_misaligned = 1'b0;
                w_size_mask  = 8'h01;
            end
            2'd1: begin
                w_misaligned = addr[0];
                w_size_mask  = 8'h03;
            end
            2'd2: begin
                w_misaligned = |addr[1:0];
                w_size_mask  = 8'h0F;
            end
            default: begin
                w_misaligned = |addr[2:0];
                w_size_mask  = 8'hFF;
            end
        endcase
        w_illegal  = mem_r ? (funct3 == 3'b111) : funct3[2];
        w_err_cond = w_misaligned | w_illegal;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = w_err_cond ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                if (req_ready) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_valid) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend
    always_comb begin
        w_shifted = rsp_data >> {r_off, 3'b000};
        w_load    = w_shifted;
        case (r_size)
            2'd0:    w_load = {{(XLEN-8){r_sign & w_shifted[7]}},   w_shifted[7:0]};
            2'd1:    w_load = {{(XLEN-16){r_sign & w_shifted[15]}}, w_shifted[15:0]};
            2'd2:    w_load = {{(XLEN-32){r_sign & w_shifted[31]}}, w_shifted[31:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_size  <= 2'd0;
            r_sign  <= 1'b0;
            r_off   <= 3'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= 8'h00;
            r_rdata <= '0;
        end else begin
            if (w_start && !w_err_cond) begin
                r_we    <= mem_w;
                r_size  <= funct3[1:0];
                r_sign  <= ~funct3[2];
                r_off   <= addr[2:0];
                r_addr  <= {addr[AW-1:3], 3'b000};
                r_wdata <= wdata << {addr[2:0], 3'b000};
                r_wmask <= mem_w ? (w_size_mask << addr[2:0]) : 8'h00;
            end
            // Store acks carry no data; rdata keeps the last load result
            if ((r_state == S_RESP) && rsp_valid && !r_we) begin
                r_rdata <= w_load;
            end
        end
    end

    // An op that will error out never stalls the pipeline
    assign lsu_busy  = (r_state == S_REQ) | (r_state == S_RESP) | (w_start & ~w_err_cond);
    assign lsu_done  = (r_state == S_DONE);
    assign lsu_err   = (r_state == S_ERR);
    assign rdata     = r_rdata;
    assign req_valid = (r_state == S_REQ);
    assign req_we    = r_we;
    assign req_addr  = r_addr;
    assign req_wdata = r_wdata;
    assign req_wmask = r_wmask;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050243_lsu.sv
// ============================================================================
// Module   : tb_ysyx_22050243_lsu
// Purpose  : Directed self-checking bench for the load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22050243_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        mem_r;
    logic        mem_w;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        lsu_busy;
    logic        lsu_done;
    logic        lsu_err;
    logic [63:0] rdata;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic [63:0] rsp_data;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
    } req_t;

    req_t        req_q[$];
    logic [63:0] ld_q[$];

    ysyx_22050243_lsu #(.XLEN(64), .AW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .mem_r     (mem_r),
        .mem_w     (mem_w),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .lsu_busy  (lsu_busy),
        .lsu_done  (lsu_done),
        .lsu_err   (lsu_err),
        .rdata     (rdata),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete op; the bus answers after rdly stalled cycles and sdly idle RESP cycles
    task automatic do_op(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rsp,
                         input int rdly, input int sdly,
                         input logic [31:0] e_addr, input logic [63:0] e_wdata,
                         input logic [7:0] e_mask, input logic [63:0] e_rdata);
        req_t        e;
        logic [63:0] er;
        req_q.push_back('{we: w, addr: e_addr, wdata: e_wdata, mask: e_mask});
        ld_q.push_back(e_rdata);
        ex_valid  = 1'b1;
        mem_r     = r;
        mem_w     = w;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        req_ready = (rdly == 0);
        @(negedge clk);
        chk("start_busy", 64'(lsu_busy), 64'd1);
        chk("start_reqv", 64'(req_valid), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            e = req_q[0];
            chk("wait_reqv",  64'(req_valid), 64'd1);
            chk("wait_addr",  64'(req_addr), 64'(e.addr));
            chk("wait_wdata", req_wdata, e.wdata);
            chk("wait_mask",  64'(req_wmask), 64'(e.mask));
            chk("wait_busy",  64'(lsu_busy), 64'd1);
            @(posedge clk); #1;
        end
        req_ready = 1'b1;
        @(negedge clk);
        e = req_q.pop_front();
        chk("req_valid", 64'(req_valid), 64'd1);
        chk("req_we",    64'(req_we), 64'(e.we));
        chk("req_addr",  64'(req_addr), 64'(e.addr));
        chk("req_wdata", req_wdata, e.wdata);
        chk("req_wmask", 64'(req_wmask), 64'(e.mask));
        chk("req_busy",  64'(lsu_busy), 64'd1);
        chk("req_done",  64'(lsu_done), 64'd0);
        @(posedge clk); #1;
        req_ready = 1'b0;
        for (int i = 0; i < sdly; i++) begin
            @(negedge clk);
            chk("resp_wait_reqv", 64'(req_valid), 64'd0);
            chk("resp_wait_busy", 64'(lsu_busy), 64'd1);
            chk("resp_wait_done", 64'(lsu_done), 64'd0);
            @(posedge clk); #1;
        end
        rsp_valid = 1'b1;
        rsp_data  = rsp;
        @(negedge clk);
        chk("resp_busy", 64'(lsu_busy), 64'd1);
        chk("resp_done", 64'(lsu_done), 64'd0);
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        rsp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        er = ld_q.pop_front();
        chk("done_pulse", 64'(lsu_done), 64'd1);
        chk("done_busy",  64'(lsu_busy), 64'd0);
        chk("done_rdata", rdata, er);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        mem_r    = 1'b0;
        mem_w    = 1'b0;
        @(negedge clk);
        chk("after_done", 64'(lsu_done), 64'd0);
        chk("after_busy", 64'(lsu_busy), 64'd0);
        chk("after_reqv", 64'(req_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic err_op(input string tag, input logic r, input logic w,
                          input logic [2:0] f3, input logic [31:0] a);
        ex_valid = 1'b1;
        mem_r    = r;
        mem_w    = w;
        funct3   = f3;
        addr     = a;
        @(negedge clk);
        chk({tag, "_busy_n"}, 64'(lsu_busy), 64'd0);
        chk({tag, "_err_n"},  64'(lsu_err), 64'd0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        mem_r    = 1'b0;
        mem_w    = 1'b0;
        @(negedge clk);
        chk({tag, "_err_n1"},  64'(lsu_err), 64'd1);
        chk({tag, "_busy_n1"}, 64'(lsu_busy), 64'd0);
        chk({tag, "_reqv_n1"}, 64'(req_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_err_n2"},  64'(lsu_err), 64'd0);
        chk({tag, "_reqv_n2"}, 64'(req_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b1;
        ex_valid  = 1'b0;
        mem_r     = 1'b0;
        mem_w     = 1'b0;
        funct3    = 3'd0;
        addr      = 32'd0;
        wdata     = 64'd0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = 64'd0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  64'(lsu_busy), 64'd0);
        chk("rst_done",  64'(lsu_done), 64'd0);
        chk("rst_err",   64'(lsu_err), 64'd0);
        chk("rst_reqv",  64'(req_valid), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_addr",  64'(req_addr), 64'd0);
        chk("rst_mask",  64'(req_wmask), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // lb, minimum latency, sign-extended negative byte
        do_op(1'b1, 1'b0, 3'b000, 32'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0,
              32'h1000, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80);
        // lhu from the top lane
        do_op(1'b1, 1'b0, 3'b101, 32'h2006, 64'd0, 64'hBEEF_0000_0000_0000, 0, 0,
              32'h2000, 64'd0, 8'h00, 64'h0000_0000_0000_BEEF);
        // lh, negative halfword in lane 2
        do_op(1'b1, 1'b0, 3'b001, 32'h7002, 64'd0, 64'h0000_0000_8001_0000, 0, 0,
              32'h7000, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_8001);
        // lwu with a set bit 31 stays positive
        do_op(1'b1, 1'b0, 3'b110, 32'h7104, 64'd0, 64'hF234_5678_0000_0000, 1, 1,
              32'h7100, 64'd0, 8'h00, 64'h0000_0000_F234_5678);
        // sw to the upper word; rdata keeps the previous load
        do_op(1'b0, 1'b1, 3'b010, 32'h3004, 64'h0000_0000_1122_3344, 64'h5555_5555_5555_5555, 0, 0,
              32'h3000, 64'h1122_3344_0000_0000, 8'hF0, 64'h0000_0000_F234_5678);
        // sb to byte 5
        do_op(1'b0, 1'b1, 3'b000, 32'h3105, 64'h0000_0000_0000_00A5, 64'd0, 0, 0,
              32'h3100, 64'h0000_A500_0000_0000, 8'h20, 64'h0000_0000_F234_5678);
        // sd with ready held off 5 cycles and response delayed 3
        do_op(1'b0, 1'b1, 3'b011, 32'h6008, 64'h0123_4567_89AB_CDEF, 64'hAAAA_AAAA_AAAA_AAAA, 5, 3,
              32'h6008, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0000_0000_F234_5678);

        err_op("ld_misal",  1'b1, 1'b0, 3'b011, 32'h4004);
        err_op("lw_misal",  1'b1, 1'b0, 3'b010, 32'h4002);
        err_op("ld_ill",    1'b1, 1'b0, 3'b111, 32'h4000);
        err_op("st_ill",    1'b0, 1'b1, 3'b100, 32'h4000);

        // mem_r and mem_w both set: ignored
        ex_valid = 1'b1;
        mem_r    = 1'b1;
        mem_w    = 1'b1;
        funct3   = 3'b000;
        addr     = 32'h100;
        @(negedge clk);
        chk("both_busy", 64'(lsu_busy), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("both_reqv", 64'(req_valid), 64'd0);
        chk("both_err",  64'(lsu_err), 64'd0);
        chk("both_done", 64'(lsu_done), 64'd0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        mem_r    = 1'b0;
        mem_w    = 1'b0;

        // Reset while waiting in RESP; the late response must be dropped
        ex_valid  = 1'b1;
        mem_r     = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h5000;
        req_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rr_reqv", 64'(req_valid), 64'd1);
        @(posedge clk); #1;
        req_ready = 1'b0;
        @(negedge clk);
        chk("rr_resp_reqv", 64'(req_valid), 64'd0);
        chk("rr_resp_busy", 64'(lsu_busy), 64'd1);
        @(posedge clk); #1;
        rst      = 1'b1;
        ex_valid = 1'b0;
        mem_r    = 1'b0;
        @(posedge clk); #1;
        rst       = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        chk("rr_idle_busy", 64'(lsu_busy), 64'd0);
        chk("rr_idle_reqv", 64'(req_valid), 64'd0);
        chk("rr_idle_done", 64'(lsu_done), 64'd0);
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rr_no_done", 64'(lsu_done), 64'd0);
            chk("rr_rdata",   rdata, 64'd0);
            @(posedge clk); #1;
        end

        chk("sb_empty", 64'(req_q.size() + ld_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
